// File: rtl/ahb_mtx_dec_param_pkg.sv
// Shared definitions for the bus-matrix decoder slice.
//   - AHB HTRANS / HRESP encodings
//   - default-slave FSM state type
//   - port_idx_w(n): width of an index that spans n ports plus the default slave
package ahb_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    DFT_IDLE = 2'd0,
    DFT_ERR1 = 2'd1,
    DFT_ERR2 = 2'd2
  } dft_state_e;

  function automatic int unsigned port_idx_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ahb_mtx_dec_param_if.sv
// Bus-side signals of one decoder instance.
//   slave  : decoder view (address/control and per-port responses in,
//            selects and muxed response out)
//   master : view of whatever drives the decoder (input stage / bench)
interface ahb_mtx_dec_param_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_LSB  = 10
);
  logic                      HREADYS;
  logic                      sel_dec;
  logic [31:ADDR_LSB]        decode_addr_dec;
  logic [1:0]                trans_dec;
  logic [NUM_PORTS-1:0]      active_dec_i;
  logic [NUM_PORTS-1:0]      readyout_dec_i;
  logic [2*NUM_PORTS-1:0]    resp_dec_i;
  logic [32*NUM_PORTS-1:0]   rdata_dec_i;

  logic [NUM_PORTS-1:0]      sel_dec_o;
  logic                      active_dec;
  logic                      HREADYOUTS;
  logic [1:0]                HRESPS;
  logic [31:0]               HRDATAS;

  modport slave (
    input  HREADYS, sel_dec, decode_addr_dec, trans_dec,
           active_dec_i, readyout_dec_i, resp_dec_i, rdata_dec_i,
    output sel_dec_o, active_dec, HREADYOUTS, HRESPS, HRDATAS
  );

  modport master (
    output HREADYS, sel_dec, decode_addr_dec, trans_dec,
           active_dec_i, readyout_dec_i, resp_dec_i, rdata_dec_i,
    input  sel_dec_o, active_dec, HREADYOUTS, HRESPS, HRDATAS
  );

endinterface

// File: rtl/ahb_mtx_dec_param_dflt_slv.sv
// Default slave for unmapped addresses: two-cycle ERROR response
// (ERR1: not ready, ERR2: ready) plus a saturating error counter.
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   dft_sel        default slave addressed and HSEL asserted
//   HREADYS        input-stage HREADY
//   trans_act      HTRANS[1] (NONSEQ or SEQ)
//   dft_ready      registered HREADYOUT of the default slave
//   dft_resp       registered HRESP of the default slave
//   err_count      number of ERROR responses started, saturating
module ahb_mtx_dflt_slv
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                dft_sel,
  input  logic                HREADYS,
  input  logic                trans_act,
  output logic                dft_ready,
  output logic [1:0]          dft_resp,
  output logic [ERRCNT_W-1:0] err_count
);

  dft_state_e          state_d, state_q;
  logic                ready_d, ready_q;
  logic [1:0]          resp_d, resp_q;
  logic [ERRCNT_W-1:0] cnt_d, cnt_q;
  logic                start_err;

  assign start_err = dft_sel & HREADYS & trans_act;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      // ERR2 behaves like IDLE for the next address phase, so a new
      // error can follow with no gap.
      DFT_IDLE, DFT_ERR2: begin
        if (start_err) begin
          state_d = DFT_ERR1;
          ready_d = 1'b0;
          resp_d  = HRESP_ERROR;
        end else begin
          state_d = DFT_IDLE;
          ready_d = 1'b1;
          resp_d  = HRESP_OKAY;
        end
      end
      // Advances regardless of HREADYS: this slave owns the ready.
      DFT_ERR1: begin
        state_d = DFT_ERR2;
        ready_d = 1'b1;
        resp_d  = HRESP_ERROR;
      end
      default: begin
        state_d = DFT_IDLE;
        ready_d = 1'b1;
        resp_d  = HRESP_OKAY;
      end
    endcase
    // ERR1 lasts exactly one cycle, so entering it marks a new error.
    if ((state_d == DFT_ERR1) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DFT_IDLE;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dft_ready = ready_q;
  assign dft_resp  = resp_q;
  assign err_count = cnt_q;

endmodule

// File: rtl/ahb_mtx_dec_param.sv
// Bus-matrix address decoder for one input port.
// Decodes HADDR[31:ADDR_LSB] against NUM_PORTS base/mask regions (lowest
// index wins), drives one-hot output-stage selects, routes unmapped
// addresses to an internal default slave, and muxes the data-phase
// response from the port registered at the end of the address phase.
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   bus            decoder side of ahb_mtx_dec_param_if (slave modport)
//   err_count      saturating count of default-slave ERROR responses
module ahb_mtx_dec_param
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_LSB  = 10,
  parameter logic [NUM_PORTS*(32-ADDR_LSB)-1:0] REGION_BASE = '0,
  parameter logic [NUM_PORTS*(32-ADDR_LSB)-1:0] REGION_MASK = '0,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_mtx_dec_param_if.slave  bus,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int unsigned     RW      = 32 - ADDR_LSB;
  localparam int unsigned     IDX_W   = port_idx_w(NUM_PORTS);
  localparam logic [IDX_W-1:0] DFT_IDX = IDX_W'(NUM_PORTS);

  logic [RW-1:0]        addr;
  logic [IDX_W-1:0]     hit_port;
  logic                 hit_found;
  logic [IDX_W-1:0]     addr_port;
  logic [IDX_W-1:0]     data_port_d, data_port_q;
  logic [NUM_PORTS-1:0] sel_o;
  logic                 active_o;
  logic                 dft_sel;
  logic                 dft_ready;
  logic [1:0]           dft_resp;
  logic                 ready_o;
  logic [1:0]           resp_o;
  logic [31:0]          rdata_o;

  assign addr = bus.decode_addr_dec;

  always_comb begin
    hit_port  = DFT_IDX;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!hit_found &&
          ((addr & REGION_MASK[i*RW +: RW]) ==
           (REGION_BASE[i*RW +: RW] & REGION_MASK[i*RW +: RW]))) begin
        hit_found = 1'b1;
        hit_port  = IDX_W'(i);
      end
    end
    // Stay on the current data-phase port during IDLE so selects do not
    // toggle between transfers.
    addr_port = hit_port;
    if ((bus.trans_dec == HTRANS_IDLE) && (data_port_q != DFT_IDX)) begin
      addr_port = data_port_q;
    end
  end

  always_comb begin
    sel_o    = '0;
    active_o = 1'b1;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (addr_port == IDX_W'(i)) begin
        sel_o[i] = bus.sel_dec;
        active_o = bus.active_dec_i[i];
      end
    end
  end

  assign dft_sel = bus.sel_dec & (addr_port == DFT_IDX);

  assign data_port_d = bus.HREADYS ? addr_port : data_port_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_port_q <= DFT_IDX;
    end else begin
      data_port_q <= data_port_d;
    end
  end

  ahb_mtx_dflt_slv #(
    .ERRCNT_W (ERRCNT_W)
  ) u_dflt_slv (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .dft_sel   (dft_sel),
    .HREADYS   (bus.HREADYS),
    .trans_act (bus.trans_dec[1]),
    .dft_ready (dft_ready),
    .dft_resp  (dft_resp),
    .err_count (err_count)
  );

  always_comb begin
    ready_o = dft_ready;
    resp_o  = dft_resp;
    rdata_o = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (data_port_q == IDX_W'(i)) begin
        ready_o = bus.readyout_dec_i[i];
        resp_o  = bus.resp_dec_i[2*i +: 2];
        rdata_o = bus.rdata_dec_i[32*i +: 32];
      end
    end
  end

  assign bus.sel_dec_o  = sel_o;
  assign bus.active_dec = active_o;
  assign bus.HREADYOUTS = ready_o;
  assign bus.HRESPS     = resp_o;
  assign bus.HRDATAS    = rdata_o;

endmodule

// File: tb/tb_ahb_mtx_dec_param.sv
// Scoreboard bench for ahb_mtx_dec_param: a driver issues one address phase
// per cycle and queues the expected select / data-phase response; a monitor
// pops and compares at each falling edge (or on an explicit probe event).
// A second instance with a 2-bit counter sees identical stimulus.
module tb_ahb_mtx_dec_param;
  import ahb_mtx_pkg::*;

  localparam int unsigned NP  = 4;
  localparam int unsigned LSB = 10;
  localparam int unsigned RW  = 32 - LSB;
  // region 3 overlaps everything with addr[31]==0 to exercise priority
  localparam logic [NP*RW-1:0] BASE = {22'h080000, 22'h100000, 22'h080000, 22'h000000};
  localparam logic [NP*RW-1:0] MASK = {22'h200000, 22'h3FFFC0, 22'h3FFFC0, 22'h3FFFC0};

  localparam logic [31:0] RD0 = 32'hD000_0000;
  localparam logic [31:0] RD1 = 32'hD000_0111;
  localparam logic [31:0] RD2 = 32'hD000_0222;
  localparam logic [31:0] RD3 = 32'hD000_0333;

  localparam logic [31:0] A_P0  = 32'h0000_0000;
  localparam logic [31:0] A_P1  = 32'h2000_1000;
  localparam logic [31:0] A_P2  = 32'h4000_0000;
  localparam logic [31:0] A_P3  = 32'h3000_0000;
  localparam logic [31:0] A_UNM = 32'hF000_0000;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [7:0] err_count;
  logic [1:0] err_count_s;

  always #5 HCLK = ~HCLK;

  ahb_mtx_dec_param_if #(.NUM_PORTS(NP), .ADDR_LSB(LSB)) bus ();
  ahb_mtx_dec_param_if #(.NUM_PORTS(NP), .ADDR_LSB(LSB)) bus_s ();

  ahb_mtx_dec_param #(
    .NUM_PORTS(NP), .ADDR_LSB(LSB), .REGION_BASE(BASE), .REGION_MASK(MASK), .ERRCNT_W(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus), .err_count(err_count)
  );

  ahb_mtx_dec_param #(
    .NUM_PORTS(NP), .ADDR_LSB(LSB), .REGION_BASE(BASE), .REGION_MASK(MASK), .ERRCNT_W(2)
  ) dut_sat (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_s), .err_count(err_count_s)
  );

  typedef struct {
    int          id;
    int          sel;    // -1: not checked
    int          act;    // -1: not checked
    int          rdy;    // -1: response not checked
    logic [1:0]  rsp;
    logic [31:0] rdata;
    int          cnt;    // -1: not checked
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  event probe;

  task automatic chk(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step%0d %s: got 0x%0h, expected 0x%0h", id, what, act, exp);
    end
  endtask

  task automatic drive(input logic rdys, input logic sel, input logic [31:0] addr, input logic [1:0] tr);
    bus.HREADYS           = rdys;
    bus.sel_dec           = sel;
    bus.decode_addr_dec   = addr[31:LSB];
    bus.trans_dec         = tr;
    bus_s.HREADYS         = rdys;
    bus_s.sel_dec         = sel;
    bus_s.decode_addr_dec = addr[31:LSB];
    bus_s.trans_dec       = tr;
  endtask

  task automatic push_exp(input int id, input int esel, input int eact, input int erdy,
                          input logic [1:0] ersp, input logic [31:0] erd, input int ecnt);
    exp_t e;
    e.id = id; e.sel = esel; e.act = eact; e.rdy = erdy;
    e.rsp = ersp; e.rdata = erd; e.cnt = ecnt;
    sb.push_back(e);
  endtask

  task automatic cyc(input int id, input logic rdys, input logic sel, input logic [31:0] addr,
                     input logic [1:0] tr, input int esel, input int eact, input int erdy,
                     input logic [1:0] ersp, input logic [31:0] erd, input int ecnt);
    @(posedge HCLK);
    #1;
    drive(rdys, sel, addr, tr);
    push_exp(id, esel, eact, erdy, ersp, erd, ecnt);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK or probe);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel >= 0) chk(e.id, "sel_dec_o", 32'(bus.sel_dec_o), 32'(e.sel));
        if (e.act >= 0) chk(e.id, "active_dec", 32'(bus.active_dec), 32'(e.act));
        if (e.rdy >= 0) begin
          chk(e.id, "HREADYOUTS", 32'(bus.HREADYOUTS), 32'(e.rdy));
          chk(e.id, "HRESPS", 32'(bus.HRESPS), 32'(e.rsp));
          chk(e.id, "HRDATAS", bus.HRDATAS, e.rdata);
        end
        if (e.cnt >= 0) begin
          chk(e.id, "err_count", 32'(err_count), 32'(e.cnt));
          chk(e.id, "err_count_w2", 32'(err_count_s), (e.cnt > 3) ? 32'd3 : 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    bus.active_dec_i     = 4'b1010;
    bus.readyout_dec_i   = 4'b1111;
    bus.resp_dec_i       = 8'b10_00_00_00;
    bus.rdata_dec_i      = {RD3, RD2, RD1, RD0};
    bus_s.active_dec_i   = 4'b1010;
    bus_s.readyout_dec_i = 4'b1111;
    bus_s.resp_dec_i     = 8'b10_00_00_00;
    bus_s.rdata_dec_i    = {RD3, RD2, RD1, RD0};
    drive(1'b1, 1'b0, A_UNM, HTRANS_IDLE);

    //  id rdy sel addr   trans          sel     act rdy rsp    rdata cnt
    cyc(0, 1, 0, A_UNM, HTRANS_IDLE,   4'b0000, -1, 1, 2'b00, 0,   0);
    cyc(1, 1, 0, A_UNM, HTRANS_IDLE,   4'b0000, -1, 1, 2'b00, 0,   0);
    @(negedge HCLK); #1; HRESETn = 1'b1;

    cyc(2,  1, 0, A_P1,  HTRANS_NONSEQ, 4'b0000, 1,  1, 2'b00, 0,   0);
    cyc(3,  1, 1, A_P1,  HTRANS_NONSEQ, 4'b0010, 1,  1, 2'b00, RD1, 0);
    cyc(4,  1, 1, A_P0,  HTRANS_NONSEQ, 4'b0001, 0,  1, 2'b00, RD1, 0);
    cyc(5,  1, 1, A_P3,  HTRANS_NONSEQ, 4'b1000, 1,  1, 2'b00, RD0, 0);
    cyc(6,  1, 1, A_UNM, HTRANS_NONSEQ, 4'b0000, 1,  1, 2'b10, RD3, 0);
    cyc(7,  0, 1, A_P2,  HTRANS_NONSEQ, 4'b0100, 0,  0, 2'b01, 0,   1);
    cyc(8,  1, 1, A_P2,  HTRANS_NONSEQ, 4'b0100, 0,  1, 2'b01, 0,   1);
    cyc(9,  1, 1, A_UNM, HTRANS_IDLE,   4'b0100, 0,  1, 2'b00, RD2, 1);
    cyc(10, 1, 1, A_UNM, HTRANS_IDLE,   4'b0100, 0,  1, 2'b00, RD2, 1);
    cyc(11, 1, 1, A_UNM, HTRANS_NONSEQ, 4'b0000, 1,  1, 2'b00, RD2, 1);
    cyc(12, 0, 1, A_UNM, HTRANS_NONSEQ, 4'b0000, 1,  0, 2'b01, 0,   2);
    cyc(13, 1, 1, A_UNM, HTRANS_NONSEQ, 4'b0000, 1,  1, 2'b01, 0,   2);
    cyc(14, 0, 1, A_UNM, HTRANS_SEQ,    4'b0000, 1,  0, 2'b01, 0,   3);
    cyc(15, 1, 1, A_UNM, HTRANS_SEQ,    4'b0000, 1,  1, 2'b01, 0,   3);
    cyc(16, 0, 1, A_UNM, HTRANS_IDLE,   4'b0000, 1,  0, 2'b01, 0,   4);
    cyc(17, 1, 1, A_UNM, HTRANS_IDLE,   4'b0000, 1,  1, 2'b01, 0,   4);
    cyc(18, 1, 1, A_UNM, HTRANS_BUSY,   4'b0000, 1,  1, 2'b00, 0,   4);
    cyc(19, 1, 1, A_UNM, HTRANS_NONSEQ, 4'b0000, 1,  1, 2'b00, 0,   4);
    cyc(20, 0, 1, A_UNM, HTRANS_IDLE,   4'b0000, 1,  0, 2'b01, 0,   5);

    // asynchronous reset while the default slave is in ERR1
    @(negedge HCLK); #1;
    HRESETn = 1'b0;
    push_exp(21, -1, -1, 1, 2'b00, 0, 0);
    #1; ->probe;

    cyc(22, 1, 1, A_UNM, HTRANS_IDLE,   4'b0000, 1,  1, 2'b00, 0,   0);
    @(negedge HCLK); #1; HRESETn = 1'b1;
    cyc(23, 1, 1, A_P1,  HTRANS_NONSEQ, 4'b0010, 1,  1, 2'b00, 0,   0);
    cyc(24, 1, 1, A_P0,  HTRANS_IDLE,   4'b0010, 1,  1, 2'b00, RD1, 0);

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge HCLK);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
